// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous single-port SRAM between the fetch
// (rom_*) and data (ram_*) ports. Data access goes first, then the fetch, and
// the pipeline is held via stallreq_o until a one-cycle DONE state.
// Optional: define SRAM_ARB_FETCH_BUF_EN for a one-entry fetch buffer that
// skips the SRAM read when the same instruction word is fetched again.
module sram_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  input  logic              ram_ce_i,
  input  logic              ram_we_i,
  input  logic [3:0]        ram_sel_i,
  input  logic [31:0]       ram_addr_i,
  input  logic [31:0]       ram_data_i,
  output logic [31:0]       ram_data_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_data_o,
  input  logic [31:0]       sram_data_i,
  output logic              sram_data_oe_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o
);

  localparam int CNT_MAX = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {IDLE, D_RD, D_WS, D_WP, D_WH, I_RD, DONE} state_t;

  state_t            r_state, w_nxt;
  logic [CW-1:0]     r_cnt;
  logic              w_rd_last, w_wr_last, w_fb_hit;
  logic [ADDR_W-1:0] w_ram_waddr, w_rom_waddr;

  // Next-cycle strobe values, registered below so the SRAM pins are glitch-free
  logic              w_ce_n, w_oe_n, w_we_n, w_doe;
  logic [3:0]        w_be_n;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;

  assign w_ram_waddr = ram_addr_i[ADDR_W+1:2];
  assign w_rom_waddr = rom_addr_i[ADDR_W+1:2];
  assign w_rd_last   = (r_cnt == CW'(READ_CYCLES - 1));
  assign w_wr_last   = (r_cnt == CW'(WRITE_CYCLES - 1));

  // Byte-offset and out-of-range address bits are intentionally ignored
  logic w_unused;
  assign w_unused = ^{ram_addr_i[31:ADDR_W+2], ram_addr_i[1:0],
                      rom_addr_i[31:ADDR_W+2], rom_addr_i[1:0]};

`ifdef SRAM_ARB_FETCH_BUF_EN
  // The buffered instruction is rom_data_o itself; only tag and valid live here
  logic              r_fb_vld;
  logic [ADDR_W-1:0] r_fb_addr;

  assign w_fb_hit = rom_ce_i & r_fb_vld & (r_fb_addr == w_rom_waddr);

  // Fill at the end of every fetch read; drop on a store to the same word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fb_vld  <= 1'b0;
      r_fb_addr <= '0;
    end else if (r_state == I_RD && w_rd_last) begin
      r_fb_vld  <= 1'b1;
      r_fb_addr <= w_rom_waddr;
    end else if (r_state == D_WS && w_ram_waddr == r_fb_addr) begin
      r_fb_vld  <= 1'b0;
    end
  end
`else
  assign w_fb_hit = 1'b0;
`endif

  // Stall whenever a request is outstanding; released for exactly one DONE cycle
  assign stallreq_o = rst & (r_state != DONE) &
                      ~((r_state == IDLE) & ~rom_ce_i & ~ram_ce_i);

  // Next state: data side first, fetch afterwards unless the buffer already has it
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (ram_ce_i)      w_nxt = ram_we_i ? D_WS : D_RD;
        else if (w_fb_hit) w_nxt = DONE;
        else if (rom_ce_i) w_nxt = I_RD;
      end
      D_RD: if (w_rd_last) w_nxt = (rom_ce_i && !w_fb_hit) ? I_RD : DONE;
      D_WS: w_nxt = D_WP;
      D_WP: if (w_wr_last) w_nxt = D_WH;
      D_WH: w_nxt = (rom_ce_i && !w_fb_hit) ? I_RD : DONE;
      I_RD: if (w_rd_last) w_nxt = DONE;
      DONE: w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // SRAM pin values for the state about to be entered
  always_comb begin
    w_ce_n  = 1'b1;
    w_oe_n  = 1'b1;
    w_we_n  = 1'b1;
    w_be_n  = 4'hF;
    w_doe   = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    case (w_nxt)
      D_RD: begin
        w_ce_n = 1'b0;
        w_oe_n = 1'b0;
        w_be_n = ~ram_sel_i;
        w_addr = w_ram_waddr;
      end
      I_RD: begin
        w_ce_n = 1'b0;
        w_oe_n = 1'b0;
        w_be_n = 4'h0;
        w_addr = w_rom_waddr;
      end
      D_WS, D_WP, D_WH: begin
        w_ce_n  = 1'b0;
        w_we_n  = (w_nxt != D_WP);
        w_be_n  = ~ram_sel_i;
        w_doe   = 1'b1;
        w_addr  = w_ram_waddr;
        w_wdata = ram_data_i;
      end
      default: ;
    endcase
  end

  // State, wait counter, read-data capture and registered SRAM strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      rom_data_o     <= '0;
      ram_data_o     <= '0;
      sram_ce_n_o    <= 1'b1;
      sram_oe_n_o    <= 1'b1;
      sram_we_n_o    <= 1'b1;
      sram_be_n_o    <= 4'hF;
      sram_data_oe_o <= 1'b0;
      sram_addr_o    <= '0;
      sram_data_o    <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state)
        r_cnt <= '0;
      else if (((r_state == D_RD || r_state == I_RD) && !w_rd_last) ||
               (r_state == D_WP && !w_wr_last))
        r_cnt <= r_cnt + CW'(1);
      if (r_state == D_RD && w_rd_last) ram_data_o <= sram_data_i;
      if (r_state == I_RD && w_rd_last) rom_data_o <= sram_data_i;
      sram_ce_n_o    <= w_ce_n;
      sram_oe_n_o    <= w_oe_n;
      sram_we_n_o    <= w_we_n;
      sram_be_n_o    <= w_be_n;
      sram_data_oe_o <= w_doe;
      sram_addr_o    <= w_addr;
      sram_data_o    <= w_wdata;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one table row per clock cycle, with the
// expected SRAM pin state, stall and returned data, plus a mid-write reset.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_ce_i = 1'b0;
  logic [31:0] rom_addr_i = '0;
  logic [31:0] rom_data_o;
  logic        ram_ce_i = 1'b0;
  logic        ram_we_i = 1'b0;
  logic [3:0]  ram_sel_i = '0;
  logic [31:0] ram_addr_i = '0;
  logic [31:0] ram_data_i = '0;
  logic [31:0] ram_data_o;
  logic        stallreq_o;
  logic [19:0] sram_addr_o;
  logic [31:0] sram_data_o;
  logic [31:0] sram_data_i;
  logic        sram_data_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
  logic [3:0]  sram_be_n_o;

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
    .ram_ce_i(ram_ce_i), .ram_we_i(ram_we_i), .ram_sel_i(ram_sel_i),
    .ram_addr_i(ram_addr_i), .ram_data_i(ram_data_i), .ram_data_o(ram_data_o),
    .stallreq_o(stallreq_o), .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o),
    .sram_data_i(sram_data_i), .sram_data_oe_o(sram_data_oe_o),
    .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
    .sram_we_n_o(sram_we_n_o), .sram_be_n_o(sram_be_n_o)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: asynchronous read, byte-masked write while we_n is low
  logic [31:0] mem [0:255];
  bit          mem_init = 1'b0;
  assign sram_data_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h04] <= 32'h24010001;
      mem[8'h08] <= 32'h8C220000;
      mem[8'h0C] <= 32'h3C03ABCD;
      mem[8'h10] <= 32'h00430820;
      mem[8'h40] <= 32'h11223344;
      mem[8'h80] <= 32'h55667788;
      mem_init   <= 1'b1;
    end else if (!sram_ce_n_o && !sram_we_n_o) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n_o[b]) mem[sram_addr_o[7:0]][8*b +: 8] <= sram_data_o[8*b +: 8];
    end
  end

  typedef struct {
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic        ram_ce, ram_we;
    logic [3:0]  sel;
    logic [31:0] ram_addr, wdata;
    logic        e_stall, e_ce_n, e_oe_n, e_we_n;
    logic [3:0]  e_be_n;
    logic        e_doe;
    logic [19:0] e_addr;
    logic [31:0] e_rom, e_ram;
  } vec_t;

  vec_t        vq[$];
  vec_t        cur;
  logic [31:0] er = '0, em = '0;
  int          n_vec = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic rc, input logic [31:0] ra, input logic dc, input logic dw,
                        input logic [3:0] s, input logic [31:0] da, input logic [31:0] wd);
    cur.rom_ce = rc; cur.rom_addr = ra; cur.ram_ce = dc; cur.ram_we = dw;
    cur.sel = s; cur.ram_addr = da; cur.wdata = wd;
  endtask

  task automatic row(input logic st, input logic ce_n, input logic oe_n, input logic we_n,
                     input logic [3:0] be_n, input logic doe, input logic [19:0] a);
    vec_t v;
    v = cur;
    v.e_stall = st; v.e_ce_n = ce_n; v.e_oe_n = oe_n; v.e_we_n = we_n;
    v.e_be_n = be_n; v.e_doe = doe; v.e_addr = a; v.e_rom = er; v.e_ram = em;
    vq.push_back(v);
  endtask

  task automatic r_idle(input logic st);
    row(st, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 20'h0);
  endtask
  task automatic r_rd(input logic [19:0] a, input logic [3:0] be_n);
    row(1'b1, 1'b0, 1'b0, 1'b1, be_n, 1'b0, a);
  endtask
  task automatic r_wr(input logic we_n, input logic [3:0] be_n, input logic [19:0] a);
    row(1'b1, 1'b0, 1'b1, we_n, be_n, 1'b1, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;

    // ---- stimulus table (one row per cycle) ----
    set_in(0, 0, 0, 0, 4'h0, 0, 0);
    repeat (2) r_idle(0);
    // fetch 0x10 only
    set_in(1, 32'h10, 0, 0, 4'h0, 0, 0);
    r_idle(1); r_rd(20'h4, 4'h0); r_rd(20'h4, 4'h0);
    er = 32'h24010001; r_idle(0);
    // store 0x100 sel 0011 with fetch 0x20
    set_in(1, 32'h20, 1, 1, 4'b0011, 32'h100, 32'hAABBCCDD);
    r_idle(1);
    r_wr(1, 4'b1100, 20'h40); r_wr(0, 4'b1100, 20'h40);
    r_wr(0, 4'b1100, 20'h40); r_wr(1, 4'b1100, 20'h40);
    r_rd(20'h8, 4'h0); r_rd(20'h8, 4'h0);
    er = 32'h8C220000; r_idle(0);
    // load 0x200 with fetch 0x30: data read precedes fetch read
    set_in(1, 32'h30, 1, 0, 4'hF, 32'h200, 0);
    r_idle(1); r_rd(20'h80, 4'h0); r_rd(20'h80, 4'h0);
    em = 32'h55667788;
    r_rd(20'hC, 4'h0); r_rd(20'hC, 4'h0);
    er = 32'h3C03ABCD; r_idle(0);
    // store with sel 0000: sequence runs, memory untouched
    set_in(0, 0, 1, 1, 4'h0, 32'h100, 32'hFFFFFFFF);
    r_idle(1);
    r_wr(1, 4'hF, 20'h40); r_wr(0, 4'hF, 20'h40);
    r_wr(0, 4'hF, 20'h40); r_wr(1, 4'hF, 20'h40);
    r_idle(0);
    // load 0x100 sel 0101: sees the earlier byte-masked write
    set_in(0, 0, 1, 0, 4'b0101, 32'h100, 0);
    r_idle(1); r_rd(20'h40, 4'b1010); r_rd(20'h40, 4'b1010);
    em = 32'h1122CCDD; r_idle(0);
    // five idle cycles
    set_in(0, 0, 0, 0, 4'h0, 0, 0);
    repeat (5) r_idle(0);
`ifdef SRAM_ARB_FETCH_BUF_EN
    // fetch 0x40 twice: second is a buffer hit (IDLE then DONE)
    set_in(1, 32'h40, 0, 0, 4'h0, 0, 0);
    r_idle(1); r_rd(20'h10, 4'h0); r_rd(20'h10, 4'h0);
    er = 32'h00430820; r_idle(0);
    set_in(0, 0, 0, 0, 4'h0, 0, 0); r_idle(0);
    set_in(1, 32'h40, 0, 0, 4'h0, 0, 0); r_idle(1); r_idle(0);
    // store to 0x40 invalidates; next fetch reads SRAM again
    set_in(0, 0, 1, 1, 4'hF, 32'h40, 32'h12345678);
    r_idle(1);
    r_wr(1, 4'h0, 20'h10); r_wr(0, 4'h0, 20'h10);
    r_wr(0, 4'h0, 20'h10); r_wr(1, 4'h0, 20'h10);
    r_idle(0);
    set_in(1, 32'h40, 0, 0, 4'h0, 0, 0);
    r_idle(1); r_rd(20'h10, 4'h0); r_rd(20'h10, 4'h0);
    er = 32'h12345678; r_idle(0);
`endif

    // ---- reset values ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    chk("rst rom_data", rom_data_o, 32'h0);
    chk("rst ram_data", ram_data_o, 32'h0);
    chk("rst stall", {31'h0, stallreq_o}, 32'h0);
    chk("rst ce_n", {31'h0, sram_ce_n_o}, 32'h1);
    chk("rst oe_n", {31'h0, sram_oe_n_o}, 32'h1);
    chk("rst we_n", {31'h0, sram_we_n_o}, 32'h1);
    chk("rst be_n", {28'h0, sram_be_n_o}, 32'hF);
    chk("rst data_oe", {31'h0, sram_data_oe_o}, 32'h0);
    chk("rst addr", {12'h0, sram_addr_o}, 32'h0);
    chk("rst wdata", sram_data_o, 32'h0);
    rst = 1'b1;

    // ---- table-driven cycles ----
    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      rom_ce_i = vq[i].rom_ce; rom_addr_i = vq[i].rom_addr;
      ram_ce_i = vq[i].ram_ce; ram_we_i = vq[i].ram_we; ram_sel_i = vq[i].sel;
      ram_addr_i = vq[i].ram_addr; ram_data_i = vq[i].wdata;
      @(negedge clk);
      n_vec++;
      chk($sformatf("v%0d stall", i), {31'h0, stallreq_o}, {31'h0, vq[i].e_stall});
      chk($sformatf("v%0d ce_n", i), {31'h0, sram_ce_n_o}, {31'h0, vq[i].e_ce_n});
      chk($sformatf("v%0d oe_n", i), {31'h0, sram_oe_n_o}, {31'h0, vq[i].e_oe_n});
      chk($sformatf("v%0d we_n", i), {31'h0, sram_we_n_o}, {31'h0, vq[i].e_we_n});
      chk($sformatf("v%0d be_n", i), {28'h0, sram_be_n_o}, {28'h0, vq[i].e_be_n});
      chk($sformatf("v%0d data_oe", i), {31'h0, sram_data_oe_o}, {31'h0, vq[i].e_doe});
      if (!vq[i].e_ce_n) chk($sformatf("v%0d addr", i), {12'h0, sram_addr_o}, {12'h0, vq[i].e_addr});
      if (vq[i].e_doe)   chk($sformatf("v%0d wdata", i), sram_data_o, vq[i].wdata);
      chk($sformatf("v%0d rom_data", i), rom_data_o, vq[i].e_rom);
      chk($sformatf("v%0d ram_data", i), ram_data_o, vq[i].e_ram);
    end

    // ---- asynchronous reset in the middle of the write pulse ----
    @(posedge clk); #1;
    rom_ce_i = 1'b0; ram_ce_i = 1'b1; ram_we_i = 1'b1; ram_sel_i = 4'hF;
    ram_addr_i = 32'h300; ram_data_i = 32'h0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (sram_we_n_o === 1'b0) found = 1'b1;
    end
    n_vec++;
    chk("reach D_WP", {31'h0, found}, 32'h1);
    #2 rst = 1'b0;
    #1;
    n_vec++;
    chk("midwr we_n", {31'h0, sram_we_n_o}, 32'h1);
    chk("midwr ce_n", {31'h0, sram_ce_n_o}, 32'h1);
    chk("midwr data_oe", {31'h0, sram_data_oe_o}, 32'h0);
    chk("midwr stall", {31'h0, stallreq_o}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    // request still held: IDLE is the only state with idle strobes and stall high
    n_vec++;
    chk("post-rst stall", {31'h0, stallreq_o}, 32'h1);
    chk("post-rst ce_n", {31'h0, sram_ce_n_o}, 32'h1);
    ram_ce_i = 1'b0;
    #1;
    n_vec++;
    chk("post-rst idle stall", {31'h0, stallreq_o}, 32'h0);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
